multicycle_controller: RTL

- Parametrised successor to the single-cycle main decoder: a Moore FSM that sequences RV32I instructions over several cycles on a shared memory and a single ALU.
- Sits between the instruction register (op, captured when ir_write is high) and the multicycle datapath.
- Adds U-type support, an optional memory ready handshake and optional illegal-opcode trapping.

---
 rtl/multicycle_controller.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences fetch, decode, execute, memory and
// writeback steps over a shared memory and a single ALU.
module multicycle_controller #(
  parameter bit MEM_WAIT_EN  = 1'b1,
  parameter bit ILLEGAL_TRAP = 1'b1,
  parameter bit UTYPE_EN     = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [2:0] imm_src,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  typedef enum logic [3:0] {
    Fetch    = 4'h0,
    Decode   = 4'h1,
    MemAdr   = 4'h2,
    MemRead  = 4'h3,
    MemWb    = 4'h4,
    MemWrite = 4'h5,
    ExecR    = 4'h6,
    ExecI    = 4'h7,
    AluWb    = 4'h8,
    Branch   = 4'h9,
    Jal      = 4'ha,
    Jalr     = 4'hb,
    JalrPc   = 4'hc,
    Utype    = 4'hd,
    Unused   = 4'he,
    Trap     = 4'hf
  } state_e;

  // Per-state control flags; fetch/branch/utype are qualified by live inputs later.
  typedef struct packed {
    logic       fetch;
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       utype;
    logic       illegal;
  } ctrl_t;

  function automatic ctrl_t decode(state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      Fetch:    begin c.fetch = 1'b1; c.mem_read = 1'b1; c.alu_src_b = 2'b10;
                      c.result_src = 2'b10; end
      Decode:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
      MemAdr:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
      MemRead:  begin c.mem_read = 1'b1; c.adr_src = 1'b1; end
      MemWb:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
      MemWrite: begin c.mem_write = 1'b1; c.adr_src = 1'b1; end
      ExecR:    begin c.alu_src_a = 2'b10; c.alu_op = 2'b10; end
      ExecI:    begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10; end
      AluWb:    c.reg_write = 1'b1;
      Branch:   begin c.alu_src_a = 2'b10; c.alu_op = 2'b01; c.branch = 1'b1; end
      Jal:      begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_update = 1'b1; end
      Jalr:     begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
      JalrPc:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_update = 1'b1; end
      Utype:    begin c.utype = 1'b1; c.alu_src_b = 2'b01; end
      default:  c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  state_e state_q, state_d;
  ctrl_t  ctrl_q;
  logic   mem_done;
  logic   fetch_go;
  state_e unknown_st;

  assign mem_done   = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign unknown_st = ILLEGAL_TRAP ? Trap : Fetch;
  assign fetch_go   = ctrl_q.fetch & mem_done;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      Fetch:    if (mem_done) state_d = Decode;
      Decode: begin
        case (op)
          OpLoad, OpStore: state_d = MemAdr;
          OpReg:           state_d = ExecR;
          OpImm:           state_d = ExecI;
          OpBranch:        state_d = Branch;
          OpJal:           state_d = Jal;
          OpJalr:          state_d = Jalr;
          OpLui, OpAuipc:  state_d = UTYPE_EN ? Utype : unknown_st;
          default:         state_d = unknown_st;
        endcase
      end
      MemAdr:   state_d = op[5] ? MemWrite : MemRead;
      MemRead:  if (mem_done) state_d = MemWb;
      MemWrite: if (mem_done) state_d = Fetch;
      MemWb, AluWb, Branch:              state_d = Fetch;
      ExecR, ExecI, Jal, JalrPc, Utype:  state_d = AluWb;
      Jalr:     state_d = JalrPc;
      default:  state_d = state_q;  // Trap and the unused code hold until reset
    endcase
  end

  // State register with Moore outputs registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= Fetch;
      ctrl_q  <= decode(Fetch);
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode(state_d);
    end
  end

  // Output drive; everything is forced low while reset is held.
  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    imm_src    = 3'b000;
    illegal    = 1'b0;
    state      = 4'h0;
    if (rst_n) begin
      pc_write   = ctrl_q.pc_update | fetch_go | (ctrl_q.branch & zero);
      adr_src    = ctrl_q.adr_src;
      mem_read   = ctrl_q.mem_read;
      mem_write  = ctrl_q.mem_write;
      ir_write   = fetch_go;
      reg_write  = ctrl_q.reg_write;
      result_src = ctrl_q.result_src;
      // lui adds to zero, auipc adds to OldPC
      alu_src_a  = ctrl_q.utype ? (op[5] ? 2'b11 : 2'b01) : ctrl_q.alu_src_a;
      alu_src_b  = ctrl_q.alu_src_b;
      alu_op     = ctrl_q.alu_op;
      illegal    = ctrl_q.illegal;
      state      = state_q;
      case (op)
        OpStore:        imm_src = 3'b001;
        OpBranch:       imm_src = 3'b010;
        OpJal:          imm_src = 3'b011;
        OpLui, OpAuipc: imm_src = 3'b100;
        default:        imm_src = 3'b000;
      endcase
    end
  end

endmodule
